// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Prefix scan codes, frame FSM states and the queued event layout.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Valid/ready event channel from the PS/2 receiver to the move-decode logic.
interface ps2_key_receiver_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break,
        output evt_ready
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO with level count and overflow pulse.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        full       = (count_q == LW'(DEPTH));
        empty      = (count_q == '0);
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        overflow_d = push && full && !do_pop;
        wptr_d     = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = do_pop ? rptr_q + AW'(1) : rptr_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata    = mem_q[rptr_q];
    assign valid    = !empty;
    assign level    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the pad lines, deframes 11-bit frames,
// folds E0/F0 prefixes into make/break events and queues them for the consumer.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned REPORT_BREAK   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_key_receiver_if.master          evt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_stb, ps2d;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_err_q, par_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic         timeout, err, byte_stb;
    logic         frame_err_q;

    logic         ext_q, ext_d, brk_q, brk_d;
    logic         push_q, push_d;
    evt_t         evt_q, evt_d, head;
    logic         head_valid;

    // Lines idle high, so the synchronisers preset to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_stb = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    assign ps2d     = data_sync_q[SYNC_STAGES-1];
    assign timeout  = (state_q != StIdle) && !fall_stb && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        err       = 1'b0;
        byte_stb  = 1'b0;
        to_cnt_d  = (state_q == StIdle || fall_stb) ? '0 : to_cnt_q + TW'(1);
        if (timeout) begin
            state_d = StIdle;
            err     = 1'b1;
        end else if (fall_stb) begin
            unique case (state_q)
                StIdle: begin
                    if (!ps2d) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {ps2d, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_err_d = !(^{shift_q, ps2d});
                    state_d   = StStop;
                end
                StStop: begin
                    if (ps2d && !par_err_q) byte_stb = 1'b1;
                    else                    err      = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Prefix decode: the event is registered here and enters the FIFO next cycle.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        evt_d  = evt_q;
        push_d = 1'b0;
        if (err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_stb) begin
            if (shift_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == SC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                evt_d  = '{ext: ext_q, brk: brk_q, code: shift_q};
                push_d = !brk_q || (REPORT_BREAK != 0);
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            evt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= err;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            evt_q       <= evt_d;
        end
    end

    ps2_evt_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .wdata    (evt_q),
        .pop      (evt.evt_ready),
        .rdata    (head),
        .valid    (head_valid),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign evt.evt_valid = head_valid;
    assign evt.evt_code  = head.code;
    assign evt.evt_ext   = head.ext;
    assign evt.evt_break = head.brk;
    assign frame_err     = frame_err_q;

endmodule
